rr_arbiter8: RTL and testbench



---
 rtl/rr_arbiter8.sv | 146 ++++++++++++++
 tb/tb_rr_arbiter8.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered grant index and one-hot grant vector.
// Define ARB_TIMEOUT_EN to add the hold counter that forces release after HOLD_MAX cycles.
module rr_arbiter8 #(
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt,
    output logic       gnt_valid
`ifdef ARB_TIMEOUT_EN
    ,
    output logic       timeout
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    if ((HOLD_MAX < 1) || (HOLD_MAX > ((1 << CNT_W) - 1))) begin : g_bad_hold
        $error("rr_arbiter8: HOLD_MAX out of range for CNT_W");
    end

    state_t     state_q, state_d;
    logic [2:0] last_q, last_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;
    logic [2:0] win;
    logic       win_found;
    logic       release_c;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             force_c;
`endif

    // Priority search starting just after the last owner, wrapping 7 -> 0.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int unsigned off = 1; off <= 8; off++) begin
            logic [2:0] cand;
            cand = last_q + 3'(off);
            if (!win_found && req[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        idx_d     = idx_q;
        gnt_d     = gnt_q;
        valid_d   = valid_q;
        release_c = done || !req[idx_q];
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        force_c   = (cnt_q == CNT_W'(HOLD_MAX - 1));
`endif
        case (state_q)
            IDLE, RELEASE: begin
                if (win_found) begin
                    state_d = GRANT;
                    idx_d   = win;
                    gnt_d   = 8'b1 << win;
                    valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    state_d = IDLE;
                    idx_d   = '0;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
                if (release_c || force_c) begin
                    timeout_d = !release_c;
`else
                if (release_c) begin
`endif
                    state_d = RELEASE;
                    last_d  = idx_q;
                    idx_d   = '0;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 3'd7;
            idx_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

    assign gnt_idx   = idx_q;
    assign gnt       = gnt_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: reset, single-requester re-grant, full rotation,
// wrap-around, withdrawal, mid-grant reset and long hold (timeout when ARB_TIMEOUT_EN).
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [2:0] gnt_idx;
    logic [7:0] gnt;
    logic       gnt_valid;
`ifdef ARB_TIMEOUT_EN
    logic       timeout;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arbiter8 #(.HOLD_MAX(15), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] e_idx, input logic [7:0] e_gnt,
                       input logic e_v);
        checks++;
        assert (gnt_valid === e_v) else begin
            errors++;
            $error("FAIL %s gnt_valid: observed %b expected %b", tag, gnt_valid, e_v);
        end
        checks++;
        assert (gnt === e_gnt) else begin
            errors++;
            $error("FAIL %s gnt: observed %h expected %h", tag, gnt, e_gnt);
        end
        checks++;
        assert (gnt_idx === e_idx) else begin
            errors++;
            $error("FAIL %s gnt_idx: observed %0d expected %0d", tag, gnt_idx, e_idx);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic chk_to(input string tag, input logic e);
        checks++;
        assert (timeout === e) else begin
            errors++;
            $error("FAIL %s timeout: observed %b expected %b", tag, timeout, e);
        end
    endtask
`endif

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        tick();
        tick();
        chk("reset", 3'd0, 8'h00, 1'b0);
        rst = 1'b0;

        // idle with no requests, done outside GRANT ignored
        for (int i = 0; i < 5; i++) begin
            done = (i == 2);
            tick();
            chk("idle", 3'd0, 8'h00, 1'b0);
        end
        done = 1'b0;

        // single requester: grant, gap, grant
        req = 8'h01;
        tick();
        chk("single_grant", 3'd0, 8'h01, 1'b1);
        done = 1'b1;
        tick();
        chk("single_gap", 3'd0, 8'h00, 1'b0);
        done = 1'b0;
        tick();
        chk("single_regrant", 3'd0, 8'h01, 1'b1);

        // full rotation with all requesting
        req = 8'hFF;
        for (int i = 1; i <= 8; i++) begin
            done = 1'b1;
            tick();
            chk("rot_gap", 3'd0, 8'h00, 1'b0);
            done = 1'b0;
            tick();
            chk("rot_grant", 3'(i % 8), 8'h01 << (i % 8), 1'b1);
        end

        // wrap from owner 5 to requester 2
        rst = 1'b1;
        req = 8'h00;
        tick();
        chk("reset2", 3'd0, 8'h00, 1'b0);
        rst = 1'b0;
        req = 8'h20;
        tick();
        chk("own5", 3'd5, 8'h20, 1'b1);
        req  = 8'h24;
        done = 1'b1;
        tick();
        chk("wrap_gap", 3'd0, 8'h00, 1'b0);
        done = 1'b0;
        tick();
        chk("wrap_grant2", 3'd2, 8'h04, 1'b1);

        // owner 3 withdraws without done
        req  = 8'h08;
        done = 1'b1;
        tick();
        chk("to3_gap", 3'd0, 8'h00, 1'b0);
        done = 1'b0;
        tick();
        chk("own3", 3'd3, 8'h08, 1'b1);
        req = 8'h00;
        tick();
        chk("withdraw_release", 3'd0, 8'h00, 1'b0);
        tick();
        chk("withdraw_idle", 3'd0, 8'h00, 1'b0);

        // reset during a grant restores last pointer to 7
        req = 8'h10;
        tick();
        chk("own4", 3'd4, 8'h10, 1'b1);
        tick();
        chk("own4_hold", 3'd4, 8'h10, 1'b1);
        rst = 1'b1;
        tick();
        chk("reset_mid_grant", 3'd0, 8'h00, 1'b0);
        rst = 1'b0;
        req = 8'h81;
        tick();
        chk("post_reset_grant0", 3'd0, 8'h01, 1'b1);

        // long hold: stalled owner 1 with requester 2 waiting
        rst = 1'b1;
        req = 8'h00;
        tick();
        rst = 1'b0;
        req = 8'h06;
        tick();
        chk("hold_first", 3'd1, 8'h02, 1'b1);
`ifdef ARB_TIMEOUT_EN
        chk_to("hold_first", 1'b0);
        for (int i = 2; i <= 15; i++) begin
            tick();
            chk("hold_cycle", 3'd1, 8'h02, 1'b1);
            chk_to("hold_cycle", 1'b0);
        end
        tick();
        chk("forced_release", 3'd0, 8'h00, 1'b0);
        chk_to("forced_release", 1'b1);
        tick();
        chk("after_timeout", 3'd2, 8'h04, 1'b1);
        chk_to("after_timeout", 1'b0);
`else
        for (int i = 0; i < 110; i++) begin
            tick();
            chk("hold_forever", 3'd1, 8'h02, 1'b1);
        end
        done = 1'b1;
        tick();
        chk("hold_done", 3'd0, 8'h00, 1'b0);
        done = 1'b0;
        tick();
        chk("hold_next2", 3'd2, 8'h04, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
